seg_scan_driver: RTL and testbench

//   Time-multiplexed driver for a bank of NUM_DIGITS common-anode 7-segment digits.

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/hex_seg_decode.sv | 11 +
 rtl/seg_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: off pattern, bit order and hex glyph table.
// Segment vectors are {a,b,c,d,e,f,g}, active-low.
package seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      s = SEG_OFF;
      case (nib)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001101;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low 7-segment glyph.
module hex_seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous
// update, blanking, leading-zero suppression and anti-ghost dead time.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SLOT_CYC   = 100000,
   parameter int DEAD_CYC   = 16
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic                    lz_en,
   input  logic                    load,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int CW = $clog2(SLOT_CYC);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int VW = 4 * NUM_DIGITS;
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYC - 1);
   localparam logic [CW-1:0] DEAD_V    = CW'(DEAD_CYC);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]         r_slot_cnt;
   logic [IW-1:0]         r_idx;
   logic [VW-1:0]         r_pend_val, r_act_val;
   logic [NUM_DIGITS-1:0] r_pend_dp, r_act_dp;
   logic [NUM_DIGITS-1:0] r_pend_bl, r_act_bl;
   logic                  r_pend_lz, r_act_lz;
   logic [6:0]            r_seg;
   logic                  r_dp;
   logic [NUM_DIGITS-1:0] r_an;
   logic                  r_frame_start;

   logic                  w_slot_end;
   logic                  w_wrap;
   logic [NUM_DIGITS-1:0] w_nz;
   logic [NUM_DIGITS-1:0] w_dark;
   logic [3:0]            w_nib;
   logic [6:0]            w_dec_seg;
   logic                  w_lit;
   logic [NUM_DIGITS-1:0] w_an_nxt;

   assign w_slot_end = (r_slot_cnt == SLOT_LAST);
   assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot_cnt <= '0;
         r_idx      <= '0;
      end else begin
         r_slot_cnt <= w_slot_end ? '0 : r_slot_cnt + CW'(1);
         if (w_slot_end)
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end
   end

   // A load landing on the commit edge bypasses pending straight to active.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_val <= '0;
         r_pend_dp  <= '0;
         r_pend_bl  <= '0;
         r_pend_lz  <= 1'b0;
         r_act_val  <= '0;
         r_act_dp   <= '0;
         r_act_bl   <= '0;
         r_act_lz   <= 1'b0;
      end else begin
         if (load) begin
            r_pend_val <= value;
            r_pend_dp  <= dp_mask;
            r_pend_bl  <= blank_mask;
            r_pend_lz  <= lz_en;
         end
         if (w_wrap) begin
            r_act_val <= load ? value      : r_pend_val;
            r_act_dp  <= load ? dp_mask    : r_pend_dp;
            r_act_bl  <= load ? blank_mask : r_pend_bl;
            r_act_lz  <= load ? lz_en      : r_pend_lz;
         end
      end
   end

   // w_nz[i]: some nibble at position i or above is non-zero.
   always_comb begin
      w_nz   = '0;
      w_dark = '0;
      w_nz[NUM_DIGITS-1] = |r_act_val[VW-1 -: 4];
      for (int i = NUM_DIGITS - 2; i >= 0; i--)
         w_nz[i] = w_nz[i+1] | (|r_act_val[4*i +: 4]);
      w_dark[0] = r_act_bl[0];
      for (int i = 1; i < NUM_DIGITS; i++)
         w_dark[i] = r_act_bl[i] | (r_act_lz & ~w_nz[i]);
   end

   always_comb begin
      w_nib = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (r_idx == IW'(i))
            w_nib = r_act_val[4*i +: 4];
   end

   hex_seg_decode u_dec (
      .i_nibble (w_nib),
      .o_seg    (w_dec_seg)
   );

   assign w_lit = (r_slot_cnt >= DEAD_V) && !w_dark[r_idx];

   always_comb begin
      w_an_nxt = '1;
      if (w_lit)
         w_an_nxt[r_idx] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg         <= SEG_OFF;
         r_dp          <= 1'b1;
         r_an          <= '1;
         r_frame_start <= 1'b0;
      end else begin
         r_seg         <= w_lit ? w_dec_seg : SEG_OFF;
         r_dp          <= ~(w_lit & r_act_dp[r_idx]);
         r_an          <= w_an_nxt;
         r_frame_start <= w_wrap;
      end
   end

   assign seg         = r_seg;
   assign dp          = r_dp;
   assign an          = r_an;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: position-based display model, literal pins,
// random loads and mid-frame reset.
module tb_seg_scan_driver;

   localparam int N  = 4;
   localparam int SC = 8;
   localparam int DC = 2;
   localparam int FR = N * SC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = '0;
   logic [3:0]  dp_mask = '0;
   logic [3:0]  blank_mask = '0;
   logic        lz_en = 1'b0;
   logic        load = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_start;

   seg_scan_driver #(
      .NUM_DIGITS (N),
      .SLOT_CYC   (SC),
      .DEAD_CYC   (DC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .value       (value),
      .dp_mask     (dp_mask),
      .blank_mask  (blank_mask),
      .lz_en       (lz_en),
      .load        (load),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] tbl [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   // Model: m_s is the scan position since reset; frames are FR positions.
   int          m_s = 0;
   bit          m_live = 1'b0;
   logic [15:0] m_pv, m_av;
   logic [3:0]  m_pd, m_ad, m_pb, m_ab;
   logic        m_pl, m_al;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_an;
   logic        e_fs;
   int          m_slot, m_dig;
   bit          m_dark;

   always @(posedge clk) begin
      if (rst) begin
         m_s = 0;
         m_pv = '0; m_pd = '0; m_pb = '0; m_pl = 1'b0;
         m_av = '0; m_ad = '0; m_ab = '0; m_al = 1'b0;
         e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fs = 1'b0;
         m_live = 1'b1;
      end else begin
         m_slot = m_s % SC;
         m_dig  = (m_s / SC) % N;
         m_dark = m_ab[m_dig] ||
                  (m_al && m_dig > 0 && (m_av >> (4 * m_dig)) == 0);
         if (m_slot < DC || m_dark) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
         end else begin
            e_seg = tbl[(m_av >> (4 * m_dig)) & 16'hF];
            e_dp  = !m_ad[m_dig];
            e_an  = 4'hF ^ (4'h1 << m_dig);
         end
         e_fs = (m_s % FR == FR - 1);
         if (e_fs) begin
            if (load) begin
               m_av = value; m_ad = dp_mask; m_ab = blank_mask; m_al = lz_en;
            end else begin
               m_av = m_pv; m_ad = m_pd; m_ab = m_pb; m_al = m_pl;
            end
         end
         if (load) begin
            m_pv = value; m_pd = dp_mask; m_pb = blank_mask; m_pl = lz_en;
         end
         m_s++;
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (pos %0d)",
                  name, got, exp, m_s - 1);
      end
   endtask

   always @(negedge clk) begin
      if (m_live) begin
         chk("model_seg", 32'(seg), 32'(e_seg));
         chk("model_dp",  32'(dp),  32'(e_dp));
         chk("model_an",  32'(an),  32'(e_an));
         chk("model_fs",  32'(frame_start), 32'(e_fs));
         chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
         chk("dark_seg",  32'(an == 4'hF && seg != 7'h7F), 32'd0);
      end
   end

   task automatic wait_s(input int target);
      int k = 0;
      while (m_s != target && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 5000) chk("wait_timeout", 32'(m_s), 32'(target));
   endtask

   // Align to the negedge where pins show the result of position p.
   task automatic at(input int p);
      wait_s(p + 1);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                          input logic [3:0] b, input logic l);
      value = v; dp_mask = d; blank_mask = b; lz_en = l; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic pin(input string name, input logic [3:0] xan,
                      input logic [6:0] xseg);
      chk({name, "_an"},  32'(an),  32'(xan));
      chk({name, "_seg"}, 32'(seg), 32'(xseg));
   endtask

   int fs_cnt;
   int base;

   initial begin
      repeat (3) @(negedge clk);
      pin("reset", 4'hF, 7'h7F);
      chk("reset_dp", 32'(dp), 32'd1);
      chk("reset_fs", 32'(frame_start), 32'd0);
      rst = 1'b0;

      do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
      at(31);      chk("fs_pulse", 32'(frame_start), 32'd1);
      at(33);      pin("t1_dead", 4'hF, 7'h7F);
      chk("fs_low", 32'(frame_start), 32'd0);
      at(34);      pin("t1_d0", 4'b1110, 7'b0111000);
      at(45);      pin("t1_d1", 4'b1101, 7'b0001000);
      at(55);      pin("t1_d2", 4'b1011, 7'b0010010);
      at(58);      pin("t1_d3", 4'b0111, 7'b1001111);

      wait_s(58 + 1);
      do_load(16'h00A0, 4'h0, 4'h0, 1'b1);
      at(64 + 4);  pin("t2_d0", 4'b1110, 7'b0000001);
      at(64 + 12); pin("t2_d1", 4'b1101, 7'b0001000);
      at(64 + 20); pin("t2_d2", 4'hF, 7'h7F);
      at(64 + 28); pin("t2_d3", 4'hF, 7'h7F);
      do_load(16'h0000, 4'h0, 4'h0, 1'b1);
      at(96 + 3);  pin("t2z_d0", 4'b1110, 7'b0000001);
      at(96 + 11); pin("t2z_d1", 4'hF, 7'h7F);
      at(96 + 30); pin("t2z_d3", 4'hF, 7'h7F);
      do_load(16'h2222, 4'h0, 4'h0, 1'b0);

      wait_s(128 + 10);
      do_load(16'h1111, 4'h0, 4'h0, 1'b0);
      at(128 + 19); pin("t3_old_d2", 4'b1011, 7'b0010010);
      at(128 + 31); pin("t3_old_d3", 4'b0111, 7'b0010010);
      at(160 + 2);  pin("t3_new_d0", 4'b1110, 7'b1001111);
      fs_cnt = 0;
      repeat (64) begin
         @(negedge clk);
         fs_cnt += int'(frame_start);
      end
      chk("fs_rate", 32'(fs_cnt), 32'd2);

      at(224 + 28); pin("t4_pre", 4'b0111, 7'b1001111);
      wait_s(255);
      do_load(16'h3333, 4'h0, 4'h0, 1'b0);
      at(256 + 3);  pin("t4_bypass", 4'b1110, 7'b0000110);
      wait_s(256 + 5);
      do_load(16'h4444, 4'h0, 4'h0, 1'b0);
      wait_s(256 + 20);
      do_load(16'h5555, 4'h0, 4'h0, 1'b0);
      at(288 + 3);  pin("t4_last_d0", 4'b1110, 7'b0100100);
      at(288 + 12); pin("t4_last_d1", 4'b1101, 7'b0100100);

      wait_s(288 + 20);
      do_load(16'h1234, 4'b0101, 4'b0100, 1'b0);
      at(320 + 4);  pin("t5_d0", 4'b1110, 7'b1001100);
      chk("t5_d0_dp", 32'(dp), 32'd0);
      at(320 + 12); pin("t5_d1", 4'b1101, 7'b0000110);
      chk("t5_d1_dp", 32'(dp), 32'd1);
      at(320 + 20); pin("t5_d2", 4'hF, 7'h7F);
      chk("t5_d2_dp", 32'(dp), 32'd1);
      at(320 + 28); pin("t5_d3", 4'b0111, 7'b1001111);

      repeat (600) begin
         if ($urandom_range(0, 11) == 0) begin
            value      = 16'($urandom >> (4 * $urandom_range(0, 4)));
            dp_mask    = 4'($urandom);
            blank_mask = 4'($urandom) & 4'($urandom);
            lz_en      = 1'($urandom);
            load       = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      load = 1'b0;

      base = ((m_s / FR) + 1) * FR;
      wait_s(base + 4);
      do_load(16'hBEEF, 4'h0, 4'h0, 1'b0);
      wait_s(base + 20);
      rst = 1'b1;
      @(negedge clk);
      pin("t6_rst", 4'hF, 7'h7F);
      chk("t6_rst_dp", 32'(dp), 32'd1);
      chk("t6_rst_fs", 32'(frame_start), 32'd0);
      rst = 1'b0;
      at(2);       pin("t6_restart", 4'b1110, 7'b0000001);
      at(32 + 12); pin("t6_pend_lost", 4'b1101, 7'b0000001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
